gate_bist_checker: RTL



---
 rtl/gate_bist_pkg.sv | 29 ++
 rtl/gate_bist_if.sv | 37 +++
 rtl/gate_bist_pattern_gen.sv | 51 +++++
 rtl/gate_bist_checker.sv | 123 ++++++++++++
 4 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types, defaults and the golden model for the gate BIST checker.
package gate_bist_pkg;

    // Default gate width and per-pattern settle time.
    localparam int unsigned BIST_N_IN   = 4;
    localparam int unsigned BIST_SETTLE = 1;

    // Widest pattern the golden function accepts.
    localparam int unsigned BIST_MAX_N = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } bist_state_t;

    // Reduction AND over the low n bits of a zero-extended pattern.
    function automatic logic golden_and(input logic [BIST_MAX_N-1:0] pat, input int n);
        logic r;
        r = 1'b1;
        for (int i = 0; i < int'(BIST_MAX_N); i++) begin
            if (i < n) begin
                r = r & pat[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gate_bist_if.sv
// Bundle of start/result signals between the checker and its self-test wrapper.
interface gate_bist_if #(
    parameter int unsigned N_IN = 4
);
    logic              start;
    logic [N_IN-1:0]   pat_out;
    logic              dut_y;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_count;
    logic [N_IN-1:0]   first_fail;

    // Checker side.
    modport master (
        input  start,
        input  dut_y,
        output pat_out,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_fail
    );

    // Wrapper / gate side.
    modport slave (
        output start,
        output dut_y,
        input  pat_out,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_fail
    );
endinterface

// File: rtl/gate_bist_pattern_gen.sv
// Pattern counter plus settle counter; flags the sampling edge of each pattern.
module gate_bist_pattern_gen #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            run,
    output logic [N_IN-1:0] pat_out,
    output logic            sample_en,
    output logic            last_pat
);
    localparam int unsigned SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    logic [SW-1:0]   settle_q, settle_d;
    logic [N_IN-1:0] pat_q, pat_d;

    // Next pattern / settle count; the all-ones pattern is held once reached.
    always_comb begin
        pat_d     = pat_q;
        settle_d  = settle_q;
        sample_en = run && (settle_q == SW'(SETTLE));
        last_pat  = &pat_q;
        if (clear) begin
            pat_d    = '0;
            settle_d = '0;
        end else if (sample_en) begin
            settle_d = '0;
            if (!last_pat) begin
                pat_d = pat_q + N_IN'(1);
            end
        end else if (run) begin
            settle_d = settle_q + SW'(1);
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q    <= '0;
            settle_q <= '0;
        end else begin
            pat_q    <= pat_d;
            settle_q <= settle_d;
        end
    end

    assign pat_out = pat_q;

endmodule

// File: rtl/gate_bist_checker.sv
// Exhaustive AND-gate response checker: sweeps all patterns, counts mismatches.
// Optional first-failing-pattern capture is built when GATE_BIST_FIRST_FAIL_EN is defined.
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter int unsigned N_IN   = BIST_N_IN,
    parameter int unsigned SETTLE = BIST_SETTLE
) (
    input logic         clk,
    input logic         rst_n,
    gate_bist_if.master bus
);
    bist_state_t     state_q, state_d;
    logic [N_IN:0]   err_q, err_d;
    logic            pass_q, pass_d;
    logic [N_IN-1:0] pat;
    logic            sample_en;
    logic            last_pat;
    logic            start_run;
    logic            in_run;
    logic            mismatch;

    assign start_run = (state_q == StIdle) && bus.start;
    assign in_run    = (state_q == StRun);

    gate_bist_pattern_gen #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_pattern_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_run),
        .run       (in_run),
        .pat_out   (pat),
        .sample_en (sample_en),
        .last_pat  (last_pat)
    );

    // dut_y is combinational from pat, so it is compared on the sampling edge directly.
    assign mismatch = sample_en && (bus.dut_y != golden_and(BIST_MAX_N'(pat), int'(N_IN)));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (sample_en && last_pat) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        bus.busy = (state_q == StRun);
        bus.done = (state_q == StDone);
    end

    // Result next-state: clear at start, count mismatches, settle pass on entry to DONE.
    always_comb begin
        err_d  = err_q;
        pass_d = pass_q;
        if (start_run) begin
            err_d  = '0;
            pass_d = 1'b0;
        end else begin
            if (mismatch) begin
                err_d = err_q + (N_IN + 1)'(1);
            end
            if (in_run && sample_en && last_pat) begin
                pass_d = (err_d == '0);
            end
        end
    end

    // Result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            pass_q <= pass_d;
        end
    end

    assign bus.pat_out   = pat;
    assign bus.err_count = err_q;
    assign bus.pass      = pass_q;

`ifdef GATE_BIST_FIRST_FAIL_EN
    logic [N_IN-1:0] ff_q;
    logic            ff_seen_q;

    // Capture the pattern of the first mismatch in a run; later ones are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff_q      <= '0;
            ff_seen_q <= 1'b0;
        end else if (start_run) begin
            ff_q      <= '0;
            ff_seen_q <= 1'b0;
        end else if (mismatch && !ff_seen_q) begin
            ff_q      <= pat;
            ff_seen_q <= 1'b1;
        end
    end

    assign bus.first_fail = ff_q;
`else
    assign bus.first_fail = '0;
`endif

endmodule
